// File: rtl/sseg_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
// Contents:
//   state_t         scan FSM states (BLANK, FETCH, SHOW)
//   SSEG_OFF        active-low "all segments dark" pattern
//   MAX_DIGITS      widest display the controller supports
//   anode_onehot_n  one-hot active-low anode vector for a digit index
package sseg_pkg;

  typedef enum logic [1:0] {
    BLANK,
    FETCH,
    SHOW
  } state_t;

  localparam logic [7:0] SSEG_OFF   = 8'hFF;
  localparam int         MAX_DIGITS = 16;

  // Pulls exactly one anode low. The result is sized for the widest display;
  // callers truncate it to their own digit count.
  function automatic logic [MAX_DIGITS-1:0] anode_onehot_n(input logic [3:0] idx);
    return ~(16'h0001 << idx);
  endfunction

endpackage

// File: rtl/sseg_slot_timer.sv
// Loadable down-counter that times the blank and lit phases of a digit slot.
// Ports:
//   clk      system clock, rising edge
//   i_load   reload the counter with i_value (takes priority over counting)
//   i_value  reload value; the phase then lasts i_value+1 cycles
//   o_done   high while the counter sits at zero (last cycle of the phase)
module sseg_slot_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          i_load,
  input  logic [CW-1:0] i_value,
  output logic          o_done
);

  logic [CW-1:0] r_cnt;

  // The counter parks at zero once it expires. The owner reloads it on every
  // phase change, so it never has to wrap.
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode display.
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   hex_in      one nibble per digit, digit i at [4i+3:4i], digit 0 rightmost
//   dp_in       decimal point per digit (1 = lit)
//   en_mask     per-digit enable (0 = digit stays dark in its slot)
//   rom_addr    registered address to the external hex-to-pattern ROM
//   rom_data    active-low {g..a} pattern from that ROM
//   an_n        active-low anode enables, at most one low
//   sseg_n      active-low segments {dp,g,f,e,d,c,b,a}
//   frame_tick  one-cycle pulse after the last digit's slot ends
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int N_DIGITS  = 8,
  parameter int ON_CYC    = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] hex_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   en_mask,
  output logic [3:0]            rom_addr,
  input  logic [6:0]            rom_data,
  output logic [N_DIGITS-1:0]   an_n,
  output logic [7:0]            sseg_n,
  output logic                  frame_tick
);

  localparam int MAX_CYC = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int IW      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CW-1:0] ON_LOAD    = CW'(ON_CYC - 1);
  localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYC - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(N_DIGITS - 1);

  state_t r_state;
  state_t w_next_state;

  logic [IW-1:0]       r_idx;
  logic [3:0]          r_rom_addr;
  logic [N_DIGITS-1:0] r_an_n;
  logic [7:0]          r_sseg_n;
  logic                r_frame_tick;

  logic                w_timer_load;
  logic [CW-1:0]       w_timer_value;
  logic                w_timer_done;
  logic [N_DIGITS-1:0] w_an_sel;

  // A single timer serves both timed phases. It is reloaded with the lit
  // length while in FETCH and with the blank length when SHOW expires. Reset
  // also arms it with the blank length so the first slot after reset has the
  // same shape as every other slot.
  always_comb begin
    w_timer_load  = 1'b0;
    w_timer_value = BLANK_LOAD;
    if (reset) begin
      w_timer_load = 1'b1;
    end else if (r_state == FETCH) begin
      w_timer_load  = 1'b1;
      w_timer_value = ON_LOAD;
    end else if (r_state == SHOW && w_timer_done) begin
      w_timer_load = 1'b1;
    end
  end

  sseg_slot_timer #(
    .CW(CW)
  ) u_timer (
    .clk    (clk),
    .i_load (w_timer_load),
    .i_value(w_timer_value),
    .o_done (w_timer_done)
  );

  // State register for the BLANK -> FETCH -> SHOW slot sequence.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= BLANK;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FETCH always lasts exactly one cycle: the ROM answers combinationally,
  // so the pattern is ready in the cycle right after the address is loaded.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      BLANK:   if (w_timer_done) w_next_state = FETCH;
      FETCH:   w_next_state = SHOW;
      SHOW:    if (w_timer_done) w_next_state = BLANK;
      default: w_next_state = BLANK;
    endcase
  end

  assign w_an_sel = N_DIGITS'(anode_onehot_n(4'(r_idx)));

  // Datapath registers. Anodes and segments are written on the same edge so
  // no wrong pattern ever appears on a freshly enabled digit. Each input is
  // sampled in exactly one cycle of the slot, so changes made while a digit
  // is lit only show up in that digit's next slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx        <= '0;
      r_rom_addr   <= 4'h0;
      r_an_n       <= '1;
      r_sseg_n     <= SSEG_OFF;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= 1'b0;
      unique case (r_state)
        BLANK: begin
          if (w_timer_done) begin
            r_rom_addr <= hex_in[{r_idx, 2'b00} +: 4];
          end
        end
        FETCH: begin
          if (en_mask[r_idx]) begin
            r_sseg_n <= {~dp_in[r_idx], rom_data};
            r_an_n   <= w_an_sel;
          end else begin
            r_sseg_n <= SSEG_OFF;
            r_an_n   <= '1;
          end
        end
        SHOW: begin
          if (w_timer_done) begin
            r_an_n       <= '1;
            r_sseg_n     <= SSEG_OFF;
            r_frame_tick <= (r_idx == LAST_IDX);
            r_idx        <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
          end
        end
        default: begin
          r_an_n   <= '1;
          r_sseg_n <= SSEG_OFF;
        end
      endcase
    end
  end

  assign rom_addr   = r_rom_addr;
  assign an_n       = r_an_n;
  assign sseg_n     = r_sseg_n;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Scoreboard bench for sseg_scan_ctrl with 4 digits, 4 lit cycles and
// 2 blank cycles (7-cycle slot, 28-cycle frame). The stimulus queues one
// expected output word per clock cycle. A monitor pops and compares one
// word per cycle, sampling just after the falling edge.
module tb_sseg_scan_ctrl;

  localparam int N  = 4;
  localparam int ON = 4;
  localparam int BL = 2;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] sseg;
    logic       tick;
    logic       chkAddr;
    logic [3:0] addr;
    logic [7:0] cyc;
  } expT;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   hexIn;
  logic [3:0]    dpIn;
  logic [3:0]    enMask;
  logic [3:0]    romAddr;
  logic [6:0]    romData;
  logic [3:0]    anN;
  logic [7:0]    ssegN;
  logic          frameTick;

  expT   expQ[$];
  expT   mon;
  int    checks = 0;
  int    errors = 0;
  string testName = "init";

  // Standard active-low {g..a} table for hex digits 0 through F.
  function automatic logic [6:0] romPattern(input logic [3:0] a);
    case (a)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  assign romData = romPattern(romAddr);

  sseg_scan_ctrl #(
    .N_DIGITS (N),
    .ON_CYC   (ON),
    .BLANK_CYC(BL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .hex_in    (hexIn),
    .dp_in     (dpIn),
    .en_mask   (enMask),
    .rom_addr  (romAddr),
    .rom_data  (romData),
    .an_n      (anN),
    .sseg_n    (ssegN),
    .frame_tick(frameTick)
  );

  always #5 clk = ~clk;

  // Monitor: one expected word per cycle, compared 2 time units after the
  // falling edge so it never races the stimulus process.
  always @(negedge clk) begin
    #2;
    if (expQ.size() > 0) begin
      mon = expQ.pop_front();
      checks++;
      if (anN !== mon.an || ssegN !== mon.sseg || frameTick !== mon.tick) begin
        errors++;
        $display("[TB] FAIL %s cyc%0d: got an_n=%b sseg_n=%b tick=%b, want an_n=%b sseg_n=%b tick=%b",
                 testName, mon.cyc, anN, ssegN, frameTick, mon.an, mon.sseg, mon.tick);
      end
      if (mon.chkAddr) begin
        checks++;
        if (romAddr !== mon.addr) begin
          errors++;
          $display("[TB] FAIL %s rom_addr cyc%0d: got %h, want %h", testName, mon.cyc, romAddr, mon.addr);
        end
      end
    end
  end

  // Queues one frame of expected outputs. Each slot has 2 blank cycles and
  // 1 fetch cycle, all dark, followed by 4 lit cycles for an enabled digit.
  task automatic pushFrame(input logic [15:0] hex, input logic [3:0] dp, input logic [3:0] en,
                           input bit tickFirst, input bit addrFirst);
    expT        e;
    logic [3:0] oh;
    for (int d = 0; d < N; d++) begin
      for (int c = 0; c < BL + 1 + ON; c++) begin
        oh = 4'b0001 << d;
        e.cyc     = 8'(d * 7 + c);
        e.tick    = (d == 0 && c == 0) ? tickFirst : 1'b0;
        e.chkAddr = (d == 0 && c == 0) ? addrFirst : 1'b0;
        e.addr    = 4'h0;
        if (c > BL && en[d]) begin
          e.an   = ~oh;
          e.sseg = {~dp[d], romPattern(hex[4*d +: 4])};
        end else begin
          e.an   = 4'hF;
          e.sseg = 8'hFF;
        end
        expQ.push_back(e);
      end
    end
  endtask

  // Loads the inputs, pulses reset for two edges and returns at the falling
  // edge of the first cycle after reset is released.
  task automatic applyStimulus(input string name, input logic [15:0] hex,
                               input logic [3:0] dp, input logic [3:0] en);
    testName = name;
    hexIn    = hex;
    dpIn     = dp;
    enMask   = en;
    reset    = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
  endtask

  // Waits, with a bounded budget, until the monitor has used up every
  // queued expectation.
  task automatic checkOutput();
    int n = 0;
    while (expQ.size() > 0 && n < 400) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (expQ.size() > 0) begin
      errors++;
      $display("[TB] FAIL %s drain timeout: %0d words left, want 0", testName, expQ.size());
      expQ.delete();
    end
  endtask

  initial begin
    reset  = 1'b1;
    hexIn  = 16'h0;
    dpIn   = 4'h0;
    enMask = 4'hF;

    // Tests 1 and 2: basic scan, three frames, frame_tick every 28 cycles.
    applyStimulus("basic", 16'h3210, 4'h0, 4'hF);
    pushFrame(16'h3210, 4'h0, 4'hF, 1'b0, 1'b1);
    pushFrame(16'h3210, 4'h0, 4'hF, 1'b1, 1'b0);
    pushFrame(16'h3210, 4'h0, 4'hF, 1'b1, 1'b0);
    checkOutput();

    // Test 3: decimal point and the upper hex letters.
    applyStimulus("dp_hex", 16'hFEDC, 4'b0100, 4'hF);
    pushFrame(16'hFEDC, 4'b0100, 4'hF, 1'b0, 1'b1);
    pushFrame(16'hFEDC, 4'b0100, 4'hF, 1'b1, 1'b0);
    checkOutput();

    // Test 4: disabled digits stay dark, frame period unchanged.
    applyStimulus("en_mask", 16'h3210, 4'h0, 4'b1010);
    pushFrame(16'h3210, 4'h0, 4'b1010, 1'b0, 1'b1);
    pushFrame(16'h3210, 4'h0, 4'b1010, 1'b1, 1'b0);
    checkOutput();

    // Test 5: a hex change during digit 0's SHOW only shows next frame.
    applyStimulus("hex_hold", 16'h3210, 4'h0, 4'hF);
    pushFrame(16'h3210, 4'h0, 4'hF, 1'b0, 1'b1);
    pushFrame(16'h3218, 4'h0, 4'hF, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    hexIn[3:0] = 4'h8;
    checkOutput();

    // Test 6: reset in digit 2's SHOW. Queue cycles 0..18 (up to the 2nd
    // SHOW cycle of digit 2), then reset for one edge and expect a clean
    // restart with no frame_tick and rom_addr back at 0.
    applyStimulus("mid_reset", 16'h3210, 4'h0, 4'hF);
    pushFrame(16'h3210, 4'h0, 4'hF, 1'b0, 1'b1);
    while (expQ.size() > 19) void'(expQ.pop_back());
    repeat (18) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    testName = "after_reset";
    pushFrame(16'h3210, 4'h0, 4'hF, 1'b0, 1'b1);
    checkOutput();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
